evm_ballot_ctrl: RTL and testbench

- Polling-booth sequencer that sits in front of the EVM vote-counting datapath.
- The presiding officer releases one ballot at a time. The block synchronizes and validates the booth's candidate keys, then issues exactly one single-cycle vote strobe (with its candidate index) to the EVM counters.
- It enforces lockout, key release, timeout and poll-close rules, and auto-closes the poll before the 3-bit EVM counters can overflow.

---
 rtl/evm_pkg.sv | 34 +++
 rtl/evm_ballot_ctrl_if.sv | 21 ++
 rtl/evm_key_sync.sv | 46 ++++
 rtl/evm_ballot_ctrl.sv | 176 +++++++++++++++++
 tb/tb_evm_ballot_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM ballot controller.
// Optional VVPAT slip printing is enabled with the EVM_VVPAT_EN macro.
package evm_pkg;

  localparam int NUM_CAND = 4;
  localparam int CAND_W   = 2;
  localparam int CNT_W    = 3;
  localparam int POP_W    = $clog2(NUM_CAND + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    PRINT,
    ISSUE,
    LOCKOUT,
    RELEASE,
    CLOSED
  } state_t;

  // Number of pressed keys in a synchronized key vector.
  function automatic logic [POP_W-1:0] popcount(input logic [NUM_CAND-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CAND; i++) n += POP_W'(v[i]);
    return n;
  endfunction

  // Vote counter increment that sticks at the limit instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/evm_ballot_ctrl_if.sv
// Vote bus to the EVM counters plus the VVPAT printer handshake.
// vvpat_* signals only carry traffic when EVM_VVPAT_EN is defined.
interface evm_ballot_ctrl_if;
  import evm_pkg::*;

  logic [CAND_W-1:0] evm_candidate;
  logic              evm_vote;
  logic              vvpat_req;
  logic [CAND_W-1:0] vvpat_cand;
  logic              vvpat_ack;

  modport master (
    output evm_candidate, evm_vote, vvpat_req, vvpat_cand,
    input  vvpat_ack
  );

  modport slave (
    input  evm_candidate, evm_vote, vvpat_req, vvpat_cand,
    output vvpat_ack
  );
endinterface

// File: rtl/evm_key_sync.sv
// Two-flop synchronizer for the raw booth keys, followed by one-hot /
// multi-press decode and candidate index encode of the synchronized vector.
module evm_key_sync
  import evm_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CAND-1:0] key,
  output logic [NUM_CAND-1:0] ks,
  output logic                valid,
  output logic                multi,
  output logic [CAND_W-1:0]   idx
);

  logic [NUM_CAND-1:0] meta;
  logic [POP_W-1:0]    ones;

  // Synchronizer chain: key -> meta -> ks.
  // NOTE: the synchronizer flops are reset as well, so ks reads all-zero
  // (no key) immediately after reset instead of replaying stale presses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      ks   <= '0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample together, so
      // the chain really is two stages deep.
      meta <= key;
      ks   <= meta;
    end
  end

  assign ones  = popcount(ks);
  assign valid = (ones == POP_W'(1));
  assign multi = (ones >= POP_W'(2));

  // Encode the set bit; only meaningful when valid is high.
  always_comb begin
    // NOTE: default first so every path assigns idx and no latch is inferred.
    idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (ks[i]) idx = CAND_W'(i);
    end
  end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Polling-booth sequencer: arms one ballot at a time, validates the
// synchronized candidate key, issues a single-cycle vote strobe, and
// enforces lockout, key release, timeout and poll-close rules.
// Optional macro EVM_VVPAT_EN inserts a PRINT state waiting on the printer.
// MAX_VOTERS must not exceed 7 (3-bit EVM counters).
module evm_ballot_ctrl
  import evm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int MAX_VOTERS     = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ballot_en,
  input  logic                close_poll,
  input  logic [NUM_CAND-1:0] key,
  evm_ballot_ctrl_if.master   evm,
  output logic                ready_led,
  output logic                beep,
  output logic                invalid_press,
  output logic                timeout,
  output logic                poll_closed,
  output logic [CNT_W-1:0]    voters_cast
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VOTERS);

  logic [NUM_CAND-1:0] ks;
  logic                valid;
  logic                multi;
  logic [CAND_W-1:0]   idx;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [LCK_W-1:0]  lock_cnt;
  logic              close_pend;
  logic              vote_q;
  logic [CAND_W-1:0] cand_q;

  evm_key_sync u_key_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .key     (key),
    .ks      (ks),
    .valid   (valid),
    .multi   (multi),
    .idx     (idx)
  );

`ifdef EVM_VVPAT_EN
  logic              vreq_q;
  logic [CAND_W-1:0] vcand_q;
  assign evm.vvpat_req  = vreq_q;
  assign evm.vvpat_cand = vcand_q;
`else
  assign evm.vvpat_req  = 1'b0;
  assign evm.vvpat_cand = '0;
`endif

  assign evm.evm_vote      = vote_q;
  assign evm.evm_candidate = cand_q;

  // Ballot FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      lock_cnt      <= '0;
      close_pend    <= 1'b0;
      vote_q        <= 1'b0;
      cand_q        <= '0;
      ready_led     <= 1'b0;
      beep          <= 1'b0;
      invalid_press <= 1'b0;
      timeout       <= 1'b0;
      poll_closed   <= 1'b0;
      voters_cast   <= '0;
`ifdef EVM_VVPAT_EN
      vreq_q        <= 1'b0;
      vcand_q       <= '0;
`endif
    end else begin
      vote_q        <= 1'b0;
      invalid_press <= 1'b0;
      timeout       <= 1'b0;

      // A close request during a ballot is remembered until the ballot ends.
      if (close_poll && state != IDLE) close_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (close_poll || close_pend) begin
            state       <= CLOSED;
            poll_closed <= 1'b1;
          end else if (ballot_en && ks == '0) begin
            state     <= ARMED;
            ready_led <= 1'b1;
            timer     <= TMR_W'(TIMEOUT_CYCLES - 1);
          end
        end

        ARMED: begin
          if (valid) begin
            ready_led <= 1'b0;
`ifdef EVM_VVPAT_EN
            state   <= PRINT;
            vreq_q  <= 1'b1;
            vcand_q <= idx;
`else
            state       <= ISSUE;
            vote_q      <= 1'b1;
            cand_q      <= idx;
            voters_cast <= sat_inc(voters_cast, MAX_CNT);
`endif
          end else if (multi) begin
            invalid_press <= 1'b1;
            if (timer != '0) timer <= timer - 1'b1;
          end else if (timer == '0) begin
            state     <= IDLE;
            ready_led <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

`ifdef EVM_VVPAT_EN
        // Slip request held until the printer acknowledges; keys ignored.
        PRINT: begin
          if (evm.vvpat_ack) begin
            state       <= ISSUE;
            vreq_q      <= 1'b0;
            vote_q      <= 1'b1;
            cand_q      <= vcand_q;
            voters_cast <= sat_inc(voters_cast, MAX_CNT);
          end
        end
`endif

        ISSUE: begin
          state    <= LOCKOUT;
          beep     <= 1'b1;
          lock_cnt <= LCK_W'(LOCKOUT_CYCLES - 1);
        end

        LOCKOUT: begin
          if (lock_cnt == '0) begin
            state <= RELEASE;
            beep  <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

        RELEASE: begin
          if (ks == '0) begin
            if (voters_cast == MAX_CNT || close_pend) begin
              state       <= CLOSED;
              poll_closed <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        CLOSED: ;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Directed self-checking bench for evm_ballot_ctrl. Inputs change 1 time
// unit after the rising edge and outputs are sampled at that same point.
// Build with +define+EVM_VVPAT_EN to exercise the printer handshake.
module tb_evm_ballot_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ballot_en = 1'b0;
  logic       close_poll = 1'b0;
  logic [3:0] key = 4'b0000;
  logic       ready_led, beep, invalid_press, timeout, poll_closed;
  logic [2:0] voters_cast;

  evm_ballot_ctrl_if bus ();

  evm_ballot_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ballot_en     (ballot_en),
    .close_poll    (close_poll),
    .key           (key),
    .evm           (bus.master),
    .ready_led     (ready_led),
    .beep          (beep),
    .invalid_press (invalid_press),
    .timeout       (timeout),
    .poll_closed   (poll_closed),
    .voters_cast   (voters_cast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int votes    = 0;
  int consec   = 0;
  logic prev_vote = 1'b0;

  // Count vote strobes and back-to-back strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.evm_vote) votes <= votes + 1;
    if (bus.evm_vote && prev_vote) consec <= consec + 1;
    prev_vote <= bus.evm_vote;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    ballot_en  = 1'b0;
    close_poll = 1'b0;
    key        = 4'b0000;
    bus.vvpat_ack = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic arm();
    ballot_en = 1'b1;
    step(1);
    ballot_en = 1'b0;
  endtask

  // Press k on an armed booth, follow the vote through lockout, release key.
  task automatic cast(input logic [3:0] k, input logic [1:0] exp_cand,
                      input string tag);
    int v0;
    int bc;
    v0  = votes;
    key = k;
    step(2);
    check({tag, "_no_early_vote"}, bus.evm_vote, 0);
    step(1);
`ifdef EVM_VVPAT_EN
    check({tag, "_vvpat_req"}, bus.vvpat_req, 1);
    check({tag, "_vvpat_cand"}, bus.vvpat_cand, exp_cand);
    check({tag, "_no_vote_print"}, bus.evm_vote, 0);
    bus.vvpat_ack = 1'b1;
    step(1);
    bus.vvpat_ack = 1'b0;
`endif
    check({tag, "_vote"}, bus.evm_vote, 1);
    check({tag, "_cand"}, bus.evm_candidate, exp_cand);
    step(1);
    check({tag, "_vote_one_cycle"}, bus.evm_vote, 0);
    bc = 0;
    while (beep && bc < 20) begin
      bc++;
      step(1);
    end
    check({tag, "_beep_len"}, bc, 8);
    check({tag, "_cand_hold"}, bus.evm_candidate, exp_cand);
    check({tag, "_one_vote"}, votes - v0, 1);
    key = 4'b0000;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0;
    int n;
    logic [3:0] k;

    // 1. Reset state and a single vote for candidate 2.
    do_reset();
    check("rst_ready", ready_led, 0);
    check("rst_beep", beep, 0);
    check("rst_closed", poll_closed, 0);
    check("rst_voters", voters_cast, 0);
    check("rst_vote", bus.evm_vote, 0);
    check("rst_cand", bus.evm_candidate, 0);
    check("rst_invalid", invalid_press, 0);
    check("rst_timeout", timeout, 0);
    check("rst_vvpat_req", bus.vvpat_req, 0);
    arm();
    check("t1_armed", ready_led, 1);
    cast(4'b0100, 2'd2, "t1");
    check("t1_voters", voters_cast, 1);
    check("t1_ready_off", ready_led, 0);

    // 2. Two keys at once: invalid pulse, then a valid key votes.
    arm();
    v0  = votes;
    key = 4'b0011;
    step(3);
    check("t2_invalid", invalid_press, 1);
    check("t2_still_armed", ready_led, 1);
    check("t2_no_vote", votes - v0, 0);
    cast(4'b0001, 2'd0, "t2");
    check("t2_voters", voters_cast, 2);

    // 3. Timeout after 1000 armed cycles, then held key blocks arming.
    arm();
    v0 = votes;
    step(999);
    check("t3_armed_late", ready_led, 1);
    check("t3_no_timeout_yet", timeout, 0);
    step(1);
    check("t3_timeout", timeout, 1);
    check("t3_disarmed", ready_led, 0);
    step(1);
    check("t3_timeout_pulse", timeout, 0);
    check("t3_no_vote", votes - v0, 0);
    key = 4'b0010;
    step(2);
    arm();
    check("t3_held_key_no_arm", ready_led, 0);
    step(5);
    check("t3_held_key_no_vote", votes - v0, 0);
    key = 4'b0000;
    step(2);
    `ifndef EVM_VVPAT_EN
    check("t3_vvpat_tied", bus.vvpat_req, 0);
    `endif

    // 4. Seven ballots fill the counters and auto-close the poll.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      k = 4'b0001 << (i % 4);
      arm();
      cast(k, 2'(i % 4), $sformatf("t4_b%0d", i));
      if (i == 5) check("t4_open_at_6", poll_closed, 0);
    end
    check("t4_closed", poll_closed, 1);
    check("t4_voters", voters_cast, 7);
    v0 = votes;
    ballot_en = 1'b1;
    key = 4'b0001;
    step(6);
    ballot_en = 1'b0;
    key = 4'b0000;
    check("t4_no_vote_closed", votes - v0, 0);
    check("t4_no_arm_closed", ready_led, 0);
    check("t4_voters_sat", voters_cast, 7);
    step(2);

    // 5. Close request during a ballot; reset during lockout.
    do_reset();
    arm();
    close_poll = 1'b1;
    step(1);
    close_poll = 1'b0;
    check("t5_still_armed", ready_led, 1);
    check("t5_not_closed_yet", poll_closed, 0);
    cast(4'b1000, 2'd3, "t5");
    check("t5_closed", poll_closed, 1);
    do_reset();
    arm();
    key = 4'b0100;
    n = 0;
    while (!beep && n < 30) begin
      n++;
      step(1);
    end
    check("t5_in_lockout", beep, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_beep", beep, 0);
    check("t5_rst_voters", voters_cast, 0);
    check("t5_rst_cand", bus.evm_candidate, 0);
    check("t5_rst_ready", ready_led, 0);
    key = 4'b0000;
    step(2);
    reset_n = 1'b1;
    step(1);

`ifdef EVM_VVPAT_EN
    // 6. Printer acknowledge delayed 20 cycles gates the vote.
    arm();
    v0  = votes;
    key = 4'b0010;
    step(3);
    check("t6_req", bus.vvpat_req, 1);
    check("t6_cand", bus.vvpat_cand, 1);
    step(20);
    check("t6_req_held", bus.vvpat_req, 1);
    check("t6_no_vote_wait", votes - v0, 0);
    bus.vvpat_ack = 1'b1;
    step(1);
    bus.vvpat_ack = 1'b0;
    check("t6_vote", bus.evm_vote, 1);
    check("t6_vote_cand", bus.evm_candidate, 1);
    check("t6_req_drop", bus.vvpat_req, 0);
    key = 4'b0000;
    step(15);
`endif

    check("no_back_to_back_votes", consec, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
